// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the hardwired CPU sequencer: opcodes, FunSel codes,
// register masks, ALU function codes, mux selects and the control word type.
package cpu_ctrl_pkg;

   localparam logic [3:0] OP_LDI = 4'h0;
   localparam logic [3:0] OP_LD  = 4'h1;
   localparam logic [3:0] OP_ST  = 4'h2;
   localparam logic [3:0] OP_MOV = 4'h3;
   localparam logic [3:0] OP_ADD = 4'h4;
   localparam logic [3:0] OP_SUB = 4'h5;
   localparam logic [3:0] OP_AND = 4'h6;
   localparam logic [3:0] OP_OR  = 4'h7;
   localparam logic [3:0] OP_INC = 4'h8;
   localparam logic [3:0] OP_DEC = 4'h9;
   localparam logic [3:0] OP_BRA = 4'hA;
   localparam logic [3:0] OP_BEQ = 4'hB;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [1:0] FS_DEC  = 2'b00;
   localparam logic [1:0] FS_INC  = 2'b01;
   localparam logic [1:0] FS_LOAD = 2'b10;
   localparam logic [1:0] FS_CLR  = 2'b11;

   localparam logic [3:0] ARF_PC_MASK = 4'b0001;
   localparam logic [3:0] ARF_AR_MASK = 4'b0010;
   localparam logic [1:0] ARF_OUT_PC  = 2'b01;
   localparam logic [1:0] ARF_OUT_AR  = 2'b10;

   localparam logic [3:0] ALU_MOV = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0100;
   localparam logic [3:0] ALU_SUB = 4'b0101;
   localparam logic [3:0] ALU_AND = 4'b0111;
   localparam logic [3:0] ALU_OR  = 4'b1000;

   // MuxA feeds the register file, MuxB the address register file
   localparam logic [1:0] MUXA_ALU = 2'b00;
   localparam logic [1:0] MUXA_MEM = 2'b01;
   localparam logic [1:0] MUXA_IMM = 2'b10;
   localparam logic [1:0] MUXB_IMM = 2'b10;
   localparam logic       MUXC_RF  = 1'b0;

   typedef struct packed {
      logic [2:0] rf_o1sel;
      logic [2:0] rf_o2sel;
      logic [1:0] rf_funsel;
      logic [3:0] rf_rsel;
      logic [3:0] rf_tsel;
      logic [3:0] alu_funsel;
      logic [1:0] arf_outasel;
      logic [1:0] arf_outbsel;
      logic [1:0] arf_funsel;
      logic [3:0] arf_regsel;
      logic       ir_lh;
      logic       ir_enable;
      logic [1:0] ir_funsel;
      logic       mem_wr;
      logic       mem_cs;
      logic [1:0] muxasel;
      logic [1:0] muxbsel;
      logic       muxcsel;
   } ctrl_word_t;

   localparam ctrl_word_t IDLE_WORD = '{3'd0, 3'd0, 2'd0, 4'd0, 4'd0, 4'd0,
                                        2'd0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0,
                                        2'd0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0};

   function automatic logic [3:0] reg_mask(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

   // Register file outputs 4..7 are the general registers R0..R3
   function automatic logic [2:0] rf_osel(input logic [1:0] idx);
      return {1'b1, idx};
   endfunction

   function automatic logic [3:0] alu_code(input logic [3:0] op);
      case (op)
         OP_ADD:  return ALU_ADD;
         OP_SUB:  return ALU_SUB;
         OP_AND:  return ALU_AND;
         OP_OR:   return ALU_OR;
         default: return ALU_MOV;
      endcase
   endfunction

endpackage

// File: rtl/cpu_timing_counter.sv
// One-hot timing ring T0..T(T_W-1). Restart returns to T0, hold freezes the
// ring (HLT); any non-one-hot value self-corrects back to T0.
module cpu_timing_counter #(
   parameter int T_W = 8
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           hold_i,
   input  logic           restart_i,
   output logic [T_W-1:0] t_o
);

   localparam logic [T_W-1:0] T0 = T_W'(1);

   logic [T_W-1:0] t_q, t_d;
   logic           onehot;

   always_comb begin
      onehot = (t_q != '0) && ((t_q & (t_q - T_W'(1))) == '0);
      t_d    = t_q;
      if (!onehot || restart_i)
         t_d = T0;
      else if (!hold_i)
         t_d = {t_q[T_W-2:0], t_q[T_W-1]};
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) t_q <= T0;
      else       t_q <= t_d;
   end

   assign t_o = t_q;

endmodule

// File: rtl/cpu_control_unit.sv
// Hardwired sequencer: two-byte fetch in T0/T1, decode and execute in T2
// (plus T3 for memory ops), combinational control word from T, IR and Z.
module cpu_control_unit
   import cpu_ctrl_pkg::*;
#(
   parameter int T_W  = 8,
   parameter int OP_W = 4
) (
   input  logic           Clock,
   input  logic           Reset,
   input  logic [15:0]    IROut,
   input  logic [3:0]     ALUOutFlag,
   output logic [T_W-1:0] T,
   output logic [2:0]     RF_O1Sel,
   output logic [2:0]     RF_O2Sel,
   output logic [1:0]     RF_FunSel,
   output logic [3:0]     RF_RSel,
   output logic [3:0]     RF_TSel,
   output logic [3:0]     ALU_FunSel,
   output logic [1:0]     ARF_OutASel,
   output logic [1:0]     ARF_OutBSel,
   output logic [1:0]     ARF_FunSel,
   output logic [3:0]     ARF_RegSel,
   output logic           IR_LH,
   output logic           IR_Enable,
   output logic [1:0]     IR_Funsel,
   output logic           Mem_WR,
   output logic           Mem_CS,
   output logic [1:0]     MuxASel,
   output logic [1:0]     MuxBSel,
   output logic           MuxCSel
);

   logic [OP_W-1:0] op;
   logic [1:0]      rd, rs1, rs2;
   logic            is_t0, is_t1, is_t2, is_t3;
   logic            hold, restart;
   logic            z_q, z_d;
   ctrl_word_t      cw;
   logic            unused_bits;

   assign op  = IROut[15 -: OP_W];
   assign rd  = IROut[11:10];
   assign rs1 = IROut[9:8];
   assign rs2 = IROut[7:6];
   assign unused_bits = ^{ALUOutFlag[2:0], IROut[5:0]};

   assign is_t0 = (T == T_W'(1));
   assign is_t1 = (T == T_W'(2));
   assign is_t2 = (T == T_W'(4));
   assign is_t3 = (T == T_W'(8));

   cpu_timing_counter #(.T_W(T_W)) u_timing (
      .clk_i     (Clock),
      .rst_i     (Reset),
      .hold_i    (hold),
      .restart_i (restart),
      .t_o       (T)
   );

   always_comb begin
      cw      = IDLE_WORD;
      hold    = 1'b0;
      restart = 1'b1;
      z_d     = z_q;
      // Reset wins over T0's fetch word so nothing is issued while held
      if (!Reset) begin
         if (is_t0 || is_t1) begin
            restart        = 1'b0;
            cw.mem_cs      = 1'b0;
            cw.arf_outbsel = ARF_OUT_PC;
            cw.ir_enable   = 1'b1;
            cw.ir_lh       = is_t1;
            cw.ir_funsel   = FS_LOAD;
            cw.arf_funsel  = FS_INC;
            cw.arf_regsel  = ARF_PC_MASK;
         end else if (is_t2) begin
            case (op)
               OP_LDI: begin
                  cw.muxasel   = MUXA_IMM;
                  cw.rf_funsel = FS_LOAD;
                  cw.rf_rsel   = reg_mask(rd);
               end
               OP_LD, OP_ST: begin
                  restart       = 1'b0;
                  cw.muxbsel    = MUXB_IMM;
                  cw.arf_funsel = FS_LOAD;
                  cw.arf_regsel = ARF_AR_MASK;
               end
               OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                  cw.rf_o1sel   = rf_osel(rs1);
                  cw.rf_o2sel   = rf_osel(rs2);
                  cw.alu_funsel = alu_code(op);
                  cw.muxcsel    = MUXC_RF;
                  cw.muxasel    = MUXA_ALU;
                  cw.rf_funsel  = FS_LOAD;
                  cw.rf_rsel    = reg_mask(rd);
                  z_d           = ALUOutFlag[3];
               end
               OP_INC, OP_DEC: begin
                  cw.rf_funsel = (op == OP_INC) ? FS_INC : FS_DEC;
                  cw.rf_rsel   = reg_mask(rd);
               end
               OP_BRA, OP_BEQ: begin
                  if (op == OP_BRA || z_q) begin
                     cw.muxbsel    = MUXB_IMM;
                     cw.arf_funsel = FS_LOAD;
                     cw.arf_regsel = ARF_PC_MASK;
                  end
               end
               OP_HLT: begin
                  restart = 1'b0;
                  hold    = 1'b1;
               end
               default: ;
            endcase
         end else if (is_t3) begin
            cw.mem_cs      = 1'b0;
            cw.arf_outbsel = ARF_OUT_AR;
            if (op == OP_ST) begin
               // Memory data comes from the ALU passing RS1 through
               cw.mem_wr     = 1'b1;
               cw.rf_o1sel   = rf_osel(rs1);
               cw.alu_funsel = ALU_MOV;
               cw.muxcsel    = MUXC_RF;
            end else begin
               cw.muxasel   = MUXA_MEM;
               cw.rf_funsel = FS_LOAD;
               cw.rf_rsel   = reg_mask(rd);
            end
         end
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) z_q <= 1'b0;
      else       z_q <= z_d;
   end

   assign RF_O1Sel    = cw.rf_o1sel;
   assign RF_O2Sel    = cw.rf_o2sel;
   assign RF_FunSel   = cw.rf_funsel;
   assign RF_RSel     = cw.rf_rsel;
   assign RF_TSel     = cw.rf_tsel;
   assign ALU_FunSel  = cw.alu_funsel;
   assign ARF_OutASel = cw.arf_outasel;
   assign ARF_OutBSel = cw.arf_outbsel;
   assign ARF_FunSel  = cw.arf_funsel;
   assign ARF_RegSel  = cw.arf_regsel;
   assign IR_LH       = cw.ir_lh;
   assign IR_Enable   = cw.ir_enable;
   assign IR_Funsel   = cw.ir_funsel;
   assign Mem_WR      = cw.mem_wr;
   assign Mem_CS      = cw.mem_cs;
   assign MuxASel     = cw.muxasel;
   assign MuxBSel     = cw.muxbsel;
   assign MuxCSel     = cw.muxcsel;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Scoreboard bench for cpu_control_unit: each cycle's stimulus and expected
// control word are queued, then replayed and compared one clock at a time.
module tb_cpu_control_unit;

   typedef struct packed {
      logic [7:0] t;
      logic [2:0] o1;
      logic [2:0] o2;
      logic [1:0] rf_fs;
      logic [3:0] rsel;
      logic [3:0] tsel;
      logic [3:0] alu;
      logic [1:0] outa;
      logic [1:0] outb;
      logic [1:0] arf_fs;
      logic [3:0] regsel;
      logic       ir_lh;
      logic       ir_en;
      logic [1:0] ir_fs;
      logic       wr;
      logic       cs;
      logic [1:0] ma;
      logic [1:0] mb;
      logic       mc;
   } cw_t;

   typedef struct packed {
      logic [15:0] ir;
      logic [3:0]  flg;
      cw_t         exp;
   } sb_t;

   logic        Clock = 1'b0;
   logic        Reset;
   logic [15:0] IROut;
   logic [3:0]  ALUOutFlag;
   logic [7:0]  T;
   logic [2:0]  RF_O1Sel, RF_O2Sel;
   logic [1:0]  RF_FunSel;
   logic [3:0]  RF_RSel, RF_TSel, ALU_FunSel;
   logic [1:0]  ARF_OutASel, ARF_OutBSel, ARF_FunSel;
   logic [3:0]  ARF_RegSel;
   logic        IR_LH, IR_Enable;
   logic [1:0]  IR_Funsel;
   logic        Mem_WR, Mem_CS;
   logic [1:0]  MuxASel, MuxBSel;
   logic        MuxCSel;

   cw_t act;
   sb_t sb[$];
   int  passed = 0;
   int  total  = 0;
   int  wr_edges = 0;

   cpu_control_unit #(.T_W(8), .OP_W(4)) dut (
      .Clock(Clock), .Reset(Reset), .IROut(IROut), .ALUOutFlag(ALUOutFlag), .T(T),
      .RF_O1Sel(RF_O1Sel), .RF_O2Sel(RF_O2Sel), .RF_FunSel(RF_FunSel),
      .RF_RSel(RF_RSel), .RF_TSel(RF_TSel), .ALU_FunSel(ALU_FunSel),
      .ARF_OutASel(ARF_OutASel), .ARF_OutBSel(ARF_OutBSel), .ARF_FunSel(ARF_FunSel),
      .ARF_RegSel(ARF_RegSel), .IR_LH(IR_LH), .IR_Enable(IR_Enable),
      .IR_Funsel(IR_Funsel), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS),
      .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel)
   );

   assign act = {T, RF_O1Sel, RF_O2Sel, RF_FunSel, RF_RSel, RF_TSel, ALU_FunSel,
                 ARF_OutASel, ARF_OutBSel, ARF_FunSel, ARF_RegSel, IR_LH, IR_Enable,
                 IR_Funsel, Mem_WR, Mem_CS, MuxASel, MuxBSel, MuxCSel};

   always #5 Clock = ~Clock;

   // Counts rising edges that would commit a memory write
   always @(posedge Clock) if (Mem_WR === 1'b1) wr_edges++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic cw_t idle_w(input logic [7:0] t);
      cw_t w;
      w = '0;
      w.t  = t;
      w.cs = 1'b1;
      return w;
   endfunction

   function automatic cw_t fetch_w(input logic lh);
      cw_t w;
      w = idle_w(lh ? 8'h02 : 8'h01);
      w.cs     = 1'b0;
      w.outb   = 2'b01;
      w.ir_en  = 1'b1;
      w.ir_lh  = lh;
      w.ir_fs  = 2'b10;
      w.arf_fs = 2'b01;
      w.regsel = 4'b0001;
      return w;
   endfunction

   task automatic push(input logic [15:0] ir, input logic [3:0] flg, input cw_t e);
      sb.push_back('{ir: ir, flg: flg, exp: e});
   endtask

   task automatic push_fetch(input logic [15:0] ir);
      push(ir, 4'h0, fetch_w(1'b0));
      push(ir, 4'h0, fetch_w(1'b1));
   endtask

   task automatic test_reset();
      @(negedge Clock);
      #1;
      total++;
      if (act !== idle_w(8'h01)) $display("FAIL reset: got %h expected %h", act, idle_w(8'h01));
      else passed++;
      Reset = 1'b0;
   endtask

   task automatic test_ldi_ld();
      sb_t s;
      cw_t e;
      push_fetch(16'h00A5);
      e = idle_w(8'h04); e.ma = 2'b10; e.rf_fs = 2'b10; e.rsel = 4'b0001;
      push(16'h00A5, 4'h0, e);
      push_fetch(16'h1410);
      e = idle_w(8'h04); e.mb = 2'b10; e.arf_fs = 2'b10; e.regsel = 4'b0010;
      push(16'h1410, 4'h0, e);
      e = idle_w(8'h08); e.cs = 1'b0; e.outb = 2'b10; e.ma = 2'b01; e.rf_fs = 2'b10; e.rsel = 4'b0010;
      push(16'h1410, 4'h0, e);
      while (sb.size() > 0) begin
         s = sb.pop_front();
         IROut = s.ir; ALUOutFlag = s.flg;
         #1;
         total++;
         if (act !== s.exp) $display("FAIL ldi_ld ir=%h: got %h expected %h", s.ir, act, s.exp);
         else passed++;
         @(negedge Clock);
      end
   endtask

   task automatic test_st();
      sb_t s;
      cw_t e;
      int  w0;
      w0 = wr_edges;
      push_fetch(16'h2333);
      e = idle_w(8'h04); e.mb = 2'b10; e.arf_fs = 2'b10; e.regsel = 4'b0010;
      push(16'h2333, 4'h0, e);
      e = idle_w(8'h08); e.cs = 1'b0; e.wr = 1'b1; e.outb = 2'b10; e.o1 = 3'b111; e.alu = 4'b0001;
      push(16'h2333, 4'h0, e);
      while (sb.size() > 0) begin
         s = sb.pop_front();
         IROut = s.ir; ALUOutFlag = s.flg;
         #1;
         total++;
         if (act !== s.exp) $display("FAIL st ir=%h: got %h expected %h", s.ir, act, s.exp);
         else passed++;
         @(negedge Clock);
      end
      total++;
      if (wr_edges - w0 !== 1) $display("FAIL st_write_edges: got %0d expected 1", wr_edges - w0);
      else passed++;
   endtask

   task automatic test_alu_beq();
      sb_t s;
      cw_t e, beq_nt, beq_t;
      beq_nt = idle_w(8'h04);
      beq_t  = idle_w(8'h04); beq_t.mb = 2'b10; beq_t.arf_fs = 2'b10; beq_t.regsel = 4'b0001;
      push_fetch(16'hB020); push(16'hB020, 4'h0, beq_nt);
      push_fetch(16'h5000);
      e = idle_w(8'h04); e.o1 = 3'b100; e.o2 = 3'b100; e.alu = 4'b0101; e.rf_fs = 2'b10; e.rsel = 4'b0001;
      push(16'h5000, 4'b1000, e);
      push_fetch(16'hB020); push(16'hB020, 4'h0, beq_t);
      push_fetch(16'h4D80);
      e = idle_w(8'h04); e.o1 = 3'b101; e.o2 = 3'b110; e.alu = 4'b0100; e.rf_fs = 2'b10; e.rsel = 4'b1000;
      push(16'h4D80, 4'b0000, e);
      push_fetch(16'hB020); push(16'hB020, 4'h0, beq_nt);
      while (sb.size() > 0) begin
         s = sb.pop_front();
         IROut = s.ir; ALUOutFlag = s.flg;
         #1;
         total++;
         if (act !== s.exp) $display("FAIL alu_beq ir=%h: got %h expected %h", s.ir, act, s.exp);
         else passed++;
         @(negedge Clock);
      end
   endtask

   task automatic test_misc();
      sb_t s;
      cw_t e;
      push_fetch(16'h8800);
      e = idle_w(8'h04); e.rf_fs = 2'b01; e.rsel = 4'b0100;
      push(16'h8800, 4'h0, e);
      push_fetch(16'h9400);
      e = idle_w(8'h04); e.rf_fs = 2'b00; e.rsel = 4'b0010;
      push(16'h9400, 4'h0, e);
      push_fetch(16'hA07F);
      e = idle_w(8'h04); e.mb = 2'b10; e.arf_fs = 2'b10; e.regsel = 4'b0001;
      push(16'hA07F, 4'h0, e);
      push_fetch(16'hC000); push(16'hC000, 4'h0, idle_w(8'h04));
      push_fetch(16'hD3FF); push(16'hD3FF, 4'h0, idle_w(8'h04));
      while (sb.size() > 0) begin
         s = sb.pop_front();
         IROut = s.ir; ALUOutFlag = s.flg;
         #1;
         total++;
         if (act !== s.exp) $display("FAIL misc ir=%h: got %h expected %h", s.ir, act, s.exp);
         else passed++;
         @(negedge Clock);
      end
   endtask

   task automatic test_back_to_back();
      sb_t s;
      cw_t e;
      push_fetch(16'h043C);
      e = idle_w(8'h04); e.ma = 2'b10; e.rf_fs = 2'b10; e.rsel = 4'b0010;
      push(16'h043C, 4'h0, e);
      push_fetch(16'h3900);
      e = idle_w(8'h04); e.o1 = 3'b101; e.o2 = 3'b100; e.alu = 4'b0001; e.rf_fs = 2'b10; e.rsel = 4'b0100;
      push(16'h3900, 4'b1000, e);
      push_fetch(16'hB0FF);
      e = idle_w(8'h04); e.mb = 2'b10; e.arf_fs = 2'b10; e.regsel = 4'b0001;
      push(16'hB0FF, 4'h0, e);
      while (sb.size() > 0) begin
         s = sb.pop_front();
         IROut = s.ir; ALUOutFlag = s.flg;
         #1;
         total++;
         if (act !== s.exp) $display("FAIL back_to_back ir=%h: got %h expected %h", s.ir, act, s.exp);
         else passed++;
         @(negedge Clock);
      end
   endtask

   task automatic test_reset_mid_st();
      sb_t s;
      cw_t e;
      int  w0;
      w0 = wr_edges;
      push_fetch(16'h2333);
      e = idle_w(8'h04); e.mb = 2'b10; e.arf_fs = 2'b10; e.regsel = 4'b0010;
      push(16'h2333, 4'h0, e);
      while (sb.size() > 0) begin
         s = sb.pop_front();
         IROut = s.ir; ALUOutFlag = s.flg;
         #1;
         total++;
         if (act !== s.exp) $display("FAIL reset_mid_st ir=%h: got %h expected %h", s.ir, act, s.exp);
         else passed++;
         @(negedge Clock);
      end
      // now in the middle of T3
      Reset = 1'b1;
      #1;
      total++;
      if (act !== idle_w(8'h01)) $display("FAIL reset_mid_st_idle: got %h expected %h", act, idle_w(8'h01));
      else passed++;
      @(negedge Clock);
      Reset = 1'b0;
      total++;
      if (wr_edges - w0 !== 0) $display("FAIL reset_mid_st_write: got %0d write edges expected 0", wr_edges - w0);
      else passed++;
   endtask

   task automatic test_hlt();
      sb_t s;
      push_fetch(16'hF000);
      for (int i = 0; i < 21; i++) push(16'hF000, 4'h0, idle_w(8'h04));
      while (sb.size() > 0) begin
         s = sb.pop_front();
         IROut = s.ir; ALUOutFlag = s.flg;
         #1;
         total++;
         if (act !== s.exp) $display("FAIL hlt ir=%h: got %h expected %h", s.ir, act, s.exp);
         else passed++;
         @(negedge Clock);
      end
      Reset = 1'b1;
      #1;
      total++;
      if (act !== idle_w(8'h01)) $display("FAIL hlt_reset: got %h expected %h", act, idle_w(8'h01));
      else passed++;
      @(negedge Clock);
      Reset = 1'b0;
      #1;
      total++;
      if (act !== fetch_w(1'b0)) $display("FAIL hlt_release: got %h expected %h", act, fetch_w(1'b0));
      else passed++;
   endtask

   initial begin
      Reset      = 1'b1;
      IROut      = 16'h0000;
      ALUOutFlag = 4'h0;
      test_reset();
      test_ldi_ld();
      test_st();
      test_alu_beq();
      test_misc();
      test_back_to_back();
      test_reset_mid_st();
      test_hlt();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
